rpc_cmd_arbiter: RTL
====================

# rpc_cmd_arbiter

Single-issue command scheduler in front of the RPC DRAM controller command path. Arbitrates between the AXI-derived read/write command stream, register-initiated maintenance commands (mode-register set, ZQ calibration, manual refresh) and an internal periodic-refresh generator. It issues one command at a time and holds off the next command until the controller reports completion.

## Interface
- DramAddrWidth, 20, address/payload width of issued commands
- DramLenWidth, 6, burst length field width
- RefCntWidth, 16, refresh interval timer width
- MaxPostpone, 8, max refresh credits held before refresh becomes urgent (≥1)
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cfg_ref_interval_i  in  RefCntWidth  cycles per refresh credit; 0 disables the timer
- axi_valid_i / axi_ready_o  in/out  1  AXI command handshake
- axi_write_i  in  1  1 = WRITE, 0 = READ
- axi_addr_i  in  DramAddrWidth  address
- axi_len_i  in  DramLenWidth  burst length
- mnt_valid_i / mnt_ready_o  in/out  1  maintenance handshake
- mnt_op_i  in  2  0 = MRS, 1 = ZQ, 2 = REF, 3 = reserved (accepted and dropped)
- mnt_data_i  in  DramAddrWidth  MRS payload (ignored otherwise)
- cmd_valid_o / cmd_ready_i  out/in  1  command to controller
- cmd_op_o  out  3  rpc_cmd_op_e: READ = 0, WRITE = 1, REF = 2, MRS = 3, ZQ = 4
- cmd_addr_o  out  DramAddrWidth  address or payload
- cmd_len_o  out  DramLenWidth  length (0 for non-RW commands)
- cmd_done_i  in  1  single-cycle pulse: issued command finished
- ref_pending_o  out  $clog2(MaxPostpone+1)  outstanding refresh credits
- ref_overflow_o  out  1  sticky: a credit was lost at saturation
- busy_o  out  1  FSM not in IDLE

## Operation
- Refresh timer: counts 0..cfg_ref_interval_i-1. The tick fires when count ≥ interval-1, then count returns to 0. When the interval is 0, the count is held at 0 and no tick fires.
- On a tick, pending increments. If pending = MaxPostpone, pending is unchanged and ref_overflow_o is set.
- Grant priority, evaluated in IDLE only:
  1. Refresh, if pending = MaxPostpone.
  2. Maintenance (mnt_valid_i).
  3. AXI (axi_valid_i).
  4. Refresh, if pending > 0 (opportunistic).
- The granted requester sees ready = 1 for exactly one cycle, in IDLE. Its payload is latched into the output registers that cycle.
- A manual REF on mnt consumes no credit. An internally generated REF decrements pending on grant.
- A tick and a refresh grant in the same cycle leave pending unchanged.
- Reserved mnt_op: mnt_ready_o = 1 for one cycle, nothing is issued, and the FSM stays in IDLE.
- FSM:
  - IDLE → ISSUE on grant.
  - ISSUE: cmd_valid_o = 1 with stable payload until cmd_ready_i; then → WAIT.
  - WAIT → IDLE on cmd_done_i.
  - A cmd_done_i pulse outside WAIT is ignored.

## Timing
- Reset values:
  - cmd_valid_o, axi_ready_o, mnt_ready_o, busy_o, ref_overflow_o: 0
  - ref_pending_o, timer, cmd_op_o, cmd_addr_o, cmd_len_o: 0
  - FSM state: IDLE
- Grant cycle N: requester ready = 1. cmd_valid_o = 1 from N+1.
- Earliest next grant: the cycle after cmd_done_i, i.e. a minimum 3-cycle command spacing when ready and done return immediately.
- All ready outputs are 0 in ISSUE and WAIT. No combinational path from valid inputs to cmd_* outputs.
- Reset asserted mid-operation: the next edge clears state. An in-flight command is abandoned, and cmd_valid_o drops without a handshake.
- Lowering cfg_ref_interval_i below the current count produces a tick on the next cycle.

## Configuration
- RPC_ARB_REF_POSTPONE_EN defined: postponement up to MaxPostpone as described above.
- RPC_ARB_REF_POSTPONE_EN undefined:
  - The effective MaxPostpone is 1, so any pending credit is urgent and refresh preempts all traffic at the next IDLE.
  - The opportunistic step 4 becomes unreachable.

## Structure
- rpc_ctrl_pkg additions:
  - rpc_cmd_op_e enum
  - rpc_arb_cmd_t struct (op, addr, len)
  - arbiter FSM state enum
- Sub-module rpc_ref_timer: interval counter plus saturating credit counter with overflow flag. The grant logic and FSM stay in rpc_cmd_arbiter.

## Test plan
- Interval = 100 with no traffic; controller returns ready and done immediately:
  - REF is issued within 3 cycles after each tick, every 100 cycles.
  - ref_pending_o never exceeds 1.
- AXI and mnt (MRS, data 0x1234) both valid in the same cycle:
  - MRS with addr 0x1234 is issued first.
  - AXI is granted in the cycle after the MRS cmd_done_i.
- Continuous AXI traffic, interval = 10, done 5 cycles after ready (postpone enabled):
  - pending reaches 8.
  - The next grant is REF ahead of AXI.
  - pending then drops to 7.
- Tick on the same cycle as a REF grant: pending is unchanged.
- Hold cmd_ready_i = 0 for 20 cycles: cmd_* outputs stay stable and all ready outputs stay 0.
- Assert rst_i while in WAIT:
  - All outputs return to their reset values on the next edge.
  - A cmd_done_i arriving afterwards is ignored.

Source files
------------

// File: rtl/rpc_ctrl_pkg.sv
// rpc_ctrl_pkg: shared types for the RPC DRAM controller command path.
// Command opcodes, the arbiter command bundle and the arbiter FSM states.
package rpc_ctrl_pkg;

  localparam int unsigned RpcAddrW = 20;
  localparam int unsigned RpcLenW  = 6;

  typedef enum logic [2:0] {
    RPC_CMD_READ  = 3'd0,
    RPC_CMD_WRITE = 3'd1,
    RPC_CMD_REF   = 3'd2,
    RPC_CMD_MRS   = 3'd3,
    RPC_CMD_ZQ    = 3'd4
  } rpc_cmd_op_e;

  typedef enum logic [1:0] {
    RPC_MNT_MRS  = 2'd0,
    RPC_MNT_ZQ   = 2'd1,
    RPC_MNT_REF  = 2'd2,
    RPC_MNT_RSVD = 2'd3
  } rpc_mnt_op_e;

  typedef struct packed {
    rpc_cmd_op_e         op;
    logic [RpcAddrW-1:0] addr;
    logic [RpcLenW-1:0]  len;
  } rpc_arb_cmd_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } rpc_arb_state_e;

  localparam rpc_arb_cmd_t RpcArbCmdRst = '{
    op:   RPC_CMD_READ,
    addr: '0,
    len:  '0
  };

  // Only MRS carries a payload; ZQ and manual REF go out with zero fields.
  function automatic rpc_arb_cmd_t rpc_mnt_cmd(
    input logic [1:0]          op,
    input logic [RpcAddrW-1:0] data
  );
    rpc_arb_cmd_t c;
    c = '{op: RPC_CMD_REF, addr: '0, len: '0};
    case (op)
      RPC_MNT_MRS: begin
        c.op   = RPC_CMD_MRS;
        c.addr = data;
      end
      RPC_MNT_ZQ: c.op = RPC_CMD_ZQ;
      default:    c.op = RPC_CMD_REF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rpc_ref_timer.sv
// rpc_ref_timer: periodic refresh interval counter feeding a saturating
// credit counter with a sticky overflow flag.
module rpc_ref_timer
  import rpc_ctrl_pkg::*;
#(
  parameter int unsigned RefCntWidth = 16,
  parameter int unsigned MaxCredits  = 8,
  parameter int unsigned PendW       = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RefCntWidth-1:0] interval_i,
  input  logic                   consume_i,
  output logic [PendW-1:0]       pending_o,
  output logic                   overflow_o
);

  localparam logic [PendW-1:0] MaxCnt = PendW'(MaxCredits);

  logic [RefCntWidth-1:0] cnt_q, cnt_d;
  logic [PendW-1:0]       pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic                   tick;
  logic                   tmr_off;

  assign tmr_off = (interval_i == '0);

  // >= rather than == so a shrinking interval ticks right away
  assign tick = !tmr_off &&
                (cnt_q >= interval_i - RefCntWidth'(1));

  always_comb begin
    cnt_d = cnt_q + RefCntWidth'(1);
    if (tmr_off || tick) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    unique case ({tick, consume_i})
      2'b10: begin
        if (pend_q == MaxCnt) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + PendW'(1);
        end
      end
      2'b01:   pend_d = pend_q - PendW'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/rpc_cmd_arbiter.sv
// rpc_cmd_arbiter: single-issue scheduler for AXI, maintenance and refresh.
// RPC_ARB_REF_POSTPONE_EN enables refresh postponement up to MaxPostpone.
module rpc_cmd_arbiter
  import rpc_ctrl_pkg::*;
#(
  parameter int unsigned DramAddrWidth = 20,
  parameter int unsigned DramLenWidth  = 6,
  parameter int unsigned RefCntWidth   = 16,
  parameter int unsigned MaxPostpone   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [RefCntWidth-1:0]   cfg_ref_interval_i,
  input  logic                     axi_valid_i,
  output logic                     axi_ready_o,
  input  logic                     axi_write_i,
  input  logic [DramAddrWidth-1:0] axi_addr_i,
  input  logic [DramLenWidth-1:0]  axi_len_i,
  input  logic                     mnt_valid_i,
  output logic                     mnt_ready_o,
  input  logic [1:0]               mnt_op_i,
  input  logic [DramAddrWidth-1:0] mnt_data_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [2:0]               cmd_op_o,
  output logic [DramAddrWidth-1:0] cmd_addr_o,
  output logic [DramLenWidth-1:0]  cmd_len_o,
  input  logic                     cmd_done_i,
  output logic [$clog2(MaxPostpone+1)-1:0] ref_pending_o,
  output logic                     ref_overflow_o,
  output logic                     busy_o
);

  localparam int unsigned PendW = $clog2(MaxPostpone + 1);

`ifdef RPC_ARB_REF_POSTPONE_EN
  localparam int unsigned EffMax = MaxPostpone;
`else
  localparam int unsigned EffMax = 1;
`endif

  rpc_arb_state_e state_q, state_d;
  rpc_arb_cmd_t   cmd_q, cmd_d;

  logic gnt_ref;
  logic gnt_mnt;
  logic gnt_axi;
  logic urgent;
  logic idle;

  rpc_ref_timer #(
    .RefCntWidth (RefCntWidth),
    .MaxCredits  (EffMax),
    .PendW       (PendW)
  ) u_ref_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .interval_i (cfg_ref_interval_i),
    .consume_i  (gnt_ref),
    .pending_o  (ref_pending_o),
    .overflow_o (ref_overflow_o)
  );

  assign idle   = (state_q == ARB_IDLE);
  assign urgent = (ref_pending_o >= PendW'(EffMax));

  // No grant while reset is held, so no handshake is lost to the reset edge
  always_comb begin
    gnt_ref = 1'b0;
    gnt_mnt = 1'b0;
    gnt_axi = 1'b0;
    if (idle && !rst_i) begin
      if (urgent) begin
        gnt_ref = 1'b1;
      end else if (mnt_valid_i) begin
        gnt_mnt = 1'b1;
      end else if (axi_valid_i) begin
        gnt_axi = 1'b1;
`ifdef RPC_ARB_REF_POSTPONE_EN
      end else if (ref_pending_o != '0) begin
        gnt_ref = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      ARB_IDLE: begin
        unique case (1'b1)
          gnt_ref: begin
            cmd_d   = '{op: RPC_CMD_REF, addr: '0, len: '0};
            state_d = ARB_ISSUE;
          end
          gnt_mnt: begin
            // reserved op is handshaken and dropped
            if (mnt_op_i != RPC_MNT_RSVD) begin
              cmd_d   = rpc_mnt_cmd(mnt_op_i, mnt_data_i);
              state_d = ARB_ISSUE;
            end
          end
          gnt_axi: begin
            cmd_d.op   = axi_write_i ? RPC_CMD_WRITE
                                     : RPC_CMD_READ;
            cmd_d.addr = axi_addr_i;
            cmd_d.len  = axi_len_i;
            state_d    = ARB_ISSUE;
          end
          default: state_d = ARB_IDLE;
        endcase
      end
      ARB_ISSUE: begin
        if (cmd_ready_i) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cmd_done_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      cmd_q   <= RpcArbCmdRst;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  assign axi_ready_o = gnt_axi;
  assign mnt_ready_o = gnt_mnt;
  assign cmd_valid_o = (state_q == ARB_ISSUE);
  assign busy_o      = !idle;
  assign cmd_op_o    = cmd_q.op;
  assign cmd_addr_o  = cmd_q.addr;
  assign cmd_len_o   = cmd_q.len;

endmodule
